// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants, also consumed by decode and the hazard unit.
package fetch_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 32;

    localparam logic [XLEN-1:0]  RESET_PC  = 32'h0000_0000;
    localparam logic [31:0]      NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0]  PC_STEP   = XLEN'(4);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Contents of the IF/ID pipeline register.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [31:0]     instr;
        logic            valid;
    } if_id_t;

    // Bubble written into IF/ID on reset and on squash.
    localparam if_id_t IF_ID_BUBBLE = '{pc: '0, pc4: '0, instr: NOP_INSTR, valid: 1'b0};

    // Force a byte address onto a word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter: next-pc selection over reset/redirect/stall/sequential and the misalign pulse.
module pc_reg
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc,
    output logic            misalign
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            misalign_q;
    logic            misalign_d;

    // Next pc: redirect wins over stall; sequential fetch otherwise (wraps naturally).
    always_comb begin
        pc_d       = pc_q;
        misalign_d = 1'b0;
        if (redirect) begin
            pc_d       = word_align(redirect_pc);
            misalign_d = |redirect_pc[1:0];
        end else if (stall) begin
            pc_d       = pc_q;
            misalign_d = 1'b0;
        end else begin
            pc_d       = pc_q + PC_STEP;
            misalign_d = 1'b0;
        end
    end

    // PC and misalign pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc       = pc_q;
    assign misalign = misalign_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, IF/ID pipeline register with squash, and retired-fetch counter.
module fetch_stage
    import fetch_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic [XLEN-1:0]  imem_addr,
    input  logic [31:0]      imem_instr,
    output logic [XLEN-1:0]  if_id_pc,
    output logic [XLEN-1:0]  if_id_pc4,
    output logic [31:0]      if_id_instr,
    output logic             if_id_valid,
    output logic             misalign,
    output logic [CNT_W-1:0] fetch_count
);

    logic [XLEN-1:0]  pc_s;
    if_id_t           if_id_q;
    if_id_t           if_id_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    pc_reg u_pc_reg (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc_s),
        .misalign    (misalign)
    );

    // IF/ID and counter next state: squash on redirect, hold on stall, capture otherwise.
    always_comb begin
        if_id_d = if_id_q;
        count_d = count_q;
        if (redirect) begin
            if_id_d = IF_ID_BUBBLE;
            count_d = count_q;
        end else if (stall) begin
            if_id_d = if_id_q;
            count_d = count_q;
        end else begin
            if_id_d.pc    = pc_s;
            if_id_d.pc4   = pc_s + PC_STEP;
            if_id_d.instr = imem_instr;
            if_id_d.valid = 1'b1;
            count_d       = count_q + CNT_ONE;
        end
    end

    // IF/ID register and fetch counter with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_q <= IF_ID_BUBBLE;
            count_q <= '0;
        end else begin
            if_id_q <= if_id_d;
            count_q <= count_d;
        end
    end

    assign imem_addr   = pc_s;
    assign if_id_pc    = if_id_q.pc;
    assign if_id_pc4   = if_id_q.pc4;
    assign if_id_instr = if_id_q.instr;
    assign if_id_valid = if_id_q.valid;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic vs a reference model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, stall, redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr, imem_instr;
    logic [31:0] if_id_pc, if_id_pc4, if_id_instr;
    logic        if_id_valid, misalign;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_instr  (imem_instr),
        .if_id_pc    (if_id_pc),
        .if_id_pc4   (if_id_pc4),
        .if_id_instr (if_id_instr),
        .if_id_valid (if_id_valid),
        .misalign    (misalign),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    // Program memory contents: a fixed scramble of the address so every word is distinct.
    function automatic logic [31:0] prog_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Combinational imem.
    assign imem_instr = prog_word(imem_addr);

    // Reference model state.
    logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_cnt;
    logic        m_valid, m_mis;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
        if (r) begin
            m_pc = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_instr = 32'h13;
            m_valid = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
        end else if (rd) begin
            m_pc = rpc - (rpc % 32'd4);
            m_ipc = 32'h0; m_ipc4 = 32'h0; m_instr = 32'h13; m_valid = 1'b0;
            m_mis = (rpc % 32'd4) != 32'd0;
        end else if (s) begin
            m_mis = 1'b0;
        end else begin
            m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_instr = prog_word(m_pc);
            m_valid = 1'b1; m_cnt = m_cnt + 32'd1; m_pc = m_pc + 32'd4; m_mis = 1'b0;
        end
    endtask

    // Apply one cycle of inputs, advance model, compare all outputs after the edge.
    task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
        reset = r; stall = s; redirect = rd; redirect_pc = rpc;
        @(posedge clk);
        model_edge(r, s, rd, rpc);
        #1;
        check_val("imem_addr", imem_addr, m_pc);
        check_val("if_id_pc", if_id_pc, m_ipc);
        check_val("if_id_pc4", if_id_pc4, m_ipc4);
        check_val("if_id_instr", if_id_instr, m_instr);
        check_val("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
        check_val("misalign", {31'd0, misalign}, {31'd0, m_mis});
        check_val("fetch_count", fetch_count, m_cnt);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        m_pc = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_instr = 32'h13;
        m_valid = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;

        // 1: reset then sequential fetch
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check_val("rst_addr", imem_addr, 32'h0);
        check_val("rst_instr", if_id_instr, 32'h0000_0013);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check_val("t1_pc", if_id_pc, 32'h0);
        check_val("t1_valid", {31'd0, if_id_valid}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check_val("t1_addr8", imem_addr, 32'h8);

        // 2: stall holds at addr 8
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
        check_val("t2_addr", imem_addr, 32'h8);
        check_val("t2_pc", if_id_pc, 32'h4);
        check_val("t2_cnt", fetch_count, 32'd2);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check_val("t2_rel", imem_addr, 32'hC);

        // 3: redirect to 0x40
        step(1'b0, 1'b0, 1'b1, 32'h40);
        check_val("t3_addr", imem_addr, 32'h40);
        check_val("t3_valid", {31'd0, if_id_valid}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check_val("t3_pc", if_id_pc, 32'h40);

        // 4: stall + misaligned redirect
        step(1'b0, 1'b1, 1'b1, 32'h22);
        check_val("t4_addr", imem_addr, 32'h20);
        check_val("t4_mis", {31'd0, misalign}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check_val("t4_mis_off", {31'd0, misalign}, 32'd0);

        // 5: wraparound
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check_val("t5_addr", imem_addr, 32'h0);
        check_val("t5_pc", if_id_pc, 32'hFFFF_FFFC);
        check_val("t5_pc4", if_id_pc4, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);

        // 6: reset during stall
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check_val("t6_addr", imem_addr, 32'h0);
        check_val("t6_cnt", fetch_count, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic r, s, rd;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 49) == 0);
            s   = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 7) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF)) : $urandom();
            step(r, s, rd, rpc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
